// File: rtl/status_packet_gen.sv
// Status packet source: snapshots {seq, status} and streams it as an address-led byte packet.
// Optional build macro STATUS_SEQ_AUTOINC_EN: seq advances after every packet.
module status_packet_gen #(
    parameter logic [7:0] STATUS_REG_ADDR = 8'h00,
    parameter int         PAYLOAD_BITS    = 26
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [7:0]              wd,
    input  logic [PAYLOAD_BITS-1:0] status,
    output logic [7:0]              db,
    output logic                    rq,
    input  logic                    start
);

    localparam int NB = (PAYLOAD_BITS + 6) / 8;
    localparam int WW = PAYLOAD_BITS + 6;
    localparam int CW = $clog2(NB + 1);
    localparam logic [CW-1:0] LAST = CW'(NB);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SEND
    } state_t;

    state_t                  state_q, state_n;
    logic [1:0]              mode_q, mode_n;
    logic [5:0]              seq_q, seq_n;
    logic                    pending_q, pending_n;
    logic [PAYLOAD_BITS-1:0] last_q, last_n;
    logic [WW-1:0]           word_q, word_n;
    logic [CW-1:0]           cnt_q, cnt_n;
    logic [7:0]              db_q, db_n;
    logic                    rq_q, rq_n;

    logic                    trigger;
    logic [CW-1:0]           cnt_inc;
    logic [WW-1:0]           word_sh;

    assign trigger = pending_q | ((mode_q == 2'd3) && (status != last_q));
    assign cnt_inc = cnt_q + CW'(1);
    // cnt names the byte on db now, so this selects byte cnt+1
    assign word_sh = word_q >> {cnt_q, 3'b000};

    assign db = db_q;
    assign rq = rq_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            mode_q    <= 2'd0;
            seq_q     <= 6'd0;
            pending_q <= 1'b0;
            last_q    <= '0;
            word_q    <= '0;
            cnt_q     <= '0;
            db_q      <= 8'h00;
            rq_q      <= 1'b0;
        end else begin
            state_q   <= state_n;
            mode_q    <= mode_n;
            seq_q     <= seq_n;
            pending_q <= pending_n;
            last_q    <= last_n;
            word_q    <= word_n;
            cnt_q     <= cnt_n;
            db_q      <= db_n;
            rq_q      <= rq_n;
        end
    end

    always_comb begin
        state_n   = state_q;
        mode_n    = mode_q;
        seq_n     = seq_q;
        pending_n = pending_q;
        last_n    = last_q;
        word_n    = word_q;
        cnt_n     = cnt_q;
        db_n      = db_q;
        rq_n      = rq_q;

        unique case (state_q)
            IDLE: begin
                rq_n = 1'b0;
                db_n = 8'h00;
                if (trigger) begin
                    state_n   = REQ;
                    word_n    = {seq_q, status};
                    last_n    = status;
                    pending_n = 1'b0;
                    rq_n      = 1'b1;
                    db_n      = STATUS_REG_ADDR;
                end
            end
            REQ: begin
                if (start) begin
                    state_n = SEND;
                    cnt_n   = CW'(1);
                    db_n    = word_q[7:0];
                    rq_n    = (NB > 1);
                end
            end
            SEND: begin
                if (cnt_q == LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    db_n    = 8'h00;
                    rq_n    = 1'b0;
`ifdef STATUS_SEQ_AUTOINC_EN
                    seq_n   = seq_q + 6'd1;
`endif
                end else begin
                    cnt_n = cnt_inc;
                    db_n  = word_sh[7:0];
                    rq_n  = (cnt_inc != LAST);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                db_n    = 8'h00;
                rq_n    = 1'b0;
            end
        endcase

        // a command always wins, including over the IDLE->REQ pending clear
        if (we) begin
            mode_n    = wd[7:6];
            seq_n     = wd[5:0];
            pending_n = wd[6];
        end
    end

endmodule

// File: tb/tb_status_packet_gen.sv
// Self-checking bench for status_packet_gen: directed scenarios plus randomized single shots.
module tb_status_packet_gen;

    localparam logic [7:0] ADDR = 8'h31;
    localparam int PB = 26;
    localparam int NB = (PB + 6) / 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          we = 1'b0;
    logic [7:0]    wd = 8'h00;
    logic [PB-1:0] status = '0;
    logic [7:0]    db;
    logic          rq;
    logic          start = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [5:0] m_seq = 6'd0;
    int w;

    status_packet_gen #(
        .STATUS_REG_ADDR(ADDR),
        .PAYLOAD_BITS(PB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .we(we),
        .wd(wd),
        .status(status),
        .db(db),
        .rq(rq),
        .start(start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [7:0] v);
        we = 1'b1;
        wd = v;
        tick();
        we = 1'b0;
        m_seq = v[5:0];
    endtask

    // reference: packet word is seq above status, bytes taken LSB first
    function automatic logic [7:0] pkt_byte(input logic [5:0] s, input logic [PB-1:0] st, input int k);
        logic [63:0] word;
        word = (64'(s) << PB) | 64'(st);
        return 8'((word >> (8 * (k - 1))) & 64'hFF);
    endfunction

    task automatic quiet(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            tick();
            chk({tag, "_rq"}, 32'(rq), 32'd0);
            chk({tag, "_db"}, 32'(db), 32'd0);
        end
    endtask

    task automatic expect_packet(input int delay, input int mut_byte, input bit mid_cmd,
                                 input logic [7:0] mid_val, output int waited);
        logic [5:0]    es;
        logic [PB-1:0] esnap;
        es = m_seq;
        esnap = status;
        waited = 0;
        while (rq !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        chk("rq_rise", 32'(rq), 32'd1);
        chk("addr", 32'(db), 32'(ADDR));
        for (int i = 0; i < delay; i++) begin
            if (mid_cmd && i == 0) begin
                we = 1'b1;
                wd = mid_val;
            end
            tick();
            we = 1'b0;
            if (mid_cmd && i == 0) m_seq = mid_val[5:0];
            chk("req_rq", 32'(rq), 32'd1);
            chk("req_db", 32'(db), 32'(ADDR));
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= NB; k++) begin
            chk("byte", 32'(db), 32'(pkt_byte(es, esnap, k)));
            chk("rq_byte", 32'(rq), (k != NB) ? 32'd1 : 32'd0);
            if (k == mut_byte) status = status + 1'b1;
            if (k < NB) tick();
        end
`ifdef STATUS_SEQ_AUTOINC_EN
        m_seq = m_seq + 6'd1;
`endif
        tick();
        chk("idle_rq", 32'(rq), 32'd0);
        chk("idle_db", 32'(db), 32'd0);
    endtask

    initial begin
        // reset, status toggling, stray start: nothing sent
        repeat (2) tick();
        chk("rst_rq", 32'(rq), 32'd0);
        chk("rst_db", 32'(db), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            status = PB'($urandom);
            start = 1'($urandom);
            tick();
            chk("quiet_rq", 32'(rq), 32'd0);
            chk("quiet_db", 32'(db), 32'd0);
        end
        start = 1'b0;

        // single shot, start three cycles after rq
        status = 26'h2ABCDEF;
        cmd(8'h45);
        expect_packet(3, 0, 1'b0, 8'h00, w);
        chk("latency", 32'(w), 32'd1);
        quiet(20, "single");

        // we in the IDLE->REQ cycle re-arms: two packets
        cmd(8'h42);
        we = 1'b1;
        wd = 8'h43;
        tick();
        we = 1'b0;
        expect_packet(1, 0, 1'b0, 8'h00, w);
        chk("coincide_w", 32'(w), 32'd0);
`ifdef STATUS_SEQ_AUTOINC_EN
        m_seq = 6'd4;
`else
        m_seq = 6'd3;
`endif
        expect_packet(0, 0, 1'b0, 8'h00, w);
        quiet(20, "coincide");

        // auto mode: change during SEND gives exactly one more packet
        status = PB'($urandom);
        cmd(8'hC0);
        expect_packet(1, 2, 1'b0, 8'h00, w);
        expect_packet(2, 0, 1'b0, 8'h00, w);
        chk("auto_gap", 32'(w), 32'd1);
        quiet(40, "auto");
        cmd(8'h00);

        // mode 0 during REQ does not withdraw the packet
        status = PB'($urandom);
        cmd(8'h41);
        expect_packet(2, 0, 1'b1, 8'h01, w);
        quiet(30, "cancel");

        // sequence number wrap across three single shots
        cmd(8'h7F);
        expect_packet(0, 0, 1'b0, 8'h00, w);
        cmd({2'b01, m_seq});
        expect_packet(1, 0, 1'b0, 8'h00, w);
        cmd({2'b01, m_seq});
        expect_packet(0, 0, 1'b0, 8'h00, w);
        quiet(5, "wrap");

        // randomized single shots
        for (int r = 0; r < 12; r++) begin
            status = PB'($urandom);
            cmd({2'b01, 6'($urandom_range(0, 63))});
            expect_packet(int'($urandom_range(0, 4)), 0, 1'b0, 8'h00, w);
            repeat ($urandom_range(0, 3)) tick();
        end

        // async reset during byte 2 aborts the packet
        status = PB'($urandom);
        cmd(8'h47);
        w = 0;
        while (rq !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        chk("abort_rq_rise", 32'(rq), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("abort_byte2", 32'(db), 32'(pkt_byte(6'd7, status, 2)));
        #2 rst = 1'b1;
        #1;
        chk("abort_rq", 32'(rq), 32'd0);
        chk("abort_db", 32'(db), 32'd0);
        #1 rst = 1'b0;
        m_seq = 6'd0;
        for (int i = 0; i < 30; i++) begin
            status = PB'($urandom);
            tick();
            chk("post_rst_rq", 32'(rq), 32'd0);
            chk("post_rst_db", 32'(db), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
